mem_port_arbiter: RTL and testbench

- Shares the core's single memory port between instruction fetch (IF stage, beside IF_ID_CU) and the data-memory stage.
- Runs a request/done handshake on each side, drives one memory request at a time, and raises per-side stall signals.
- Data has priority, with a bounded streak so fetch is never starved.
- Supports branch-flush kill of an in-flight fetch and a watchdog timeout.

---
 rtl/core_pkg.sv | 24 ++
 rtl/mem_port_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 357 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared types and constants for the core's memory-port arbitration.
package core_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned BE_W   = WORD_W / 8;

  // Instruction fetches always read the full word.
  localparam logic [BE_W-1:0] FETCH_BE = {BE_W{1'b1}};

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_FETCH = 2'd1,
    ARB_DATA  = 2'd2
  } arb_state_e;

  // Request payload latched onto the memory port for the duration of an access.
  typedef struct packed {
    logic              we;
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] wdata;
    logic [BE_W-1:0]   be;
  } mem_cmd_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between instruction fetch and the data
// stage: one access at a time, data first with a bounded streak, branch-flush
// kill of a fetch and a watchdog abort when memory never answers.
module mem_port_arbiter
  import core_pkg::*;
#(
  parameter int unsigned DATA_STREAK_MAX = 4,
  parameter int unsigned TIMEOUT         = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  // fetch side
  input  logic              if_req,
  input  logic [WORD_W-1:0] if_addr,
  output logic [WORD_W-1:0] if_rdata,
  output logic              if_done,
  output logic              if_stall,
  input  logic              branch_flush,
  // data side
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [WORD_W-1:0] dm_addr,
  input  logic [WORD_W-1:0] dm_wdata,
  input  logic [BE_W-1:0]   dm_be,
  output logic [WORD_W-1:0] dm_rdata,
  output logic              dm_done,
  output logic              dm_stall,
  // memory port
  output logic              mem_req,
  output logic              mem_we,
  output logic [WORD_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic [BE_W-1:0]   mem_be,
  input  logic [WORD_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              bus_error
);

  localparam int unsigned STREAK_W = $clog2(DATA_STREAK_MAX + 1);
  localparam int unsigned TMO_W    = 8;

  arb_state_e          state_q,     state_d;
  mem_cmd_t            cmd_q,       cmd_d;
  logic                mem_req_q,   mem_req_d;
  logic [WORD_W-1:0]   if_rdata_q,  if_rdata_d;
  logic [WORD_W-1:0]   dm_rdata_q,  dm_rdata_d;
  logic                if_done_q,   if_done_d;
  logic                dm_done_q,   dm_done_d;
  logic                bus_error_q, bus_error_d;
  logic                kill_q,      kill_d;
  logic [STREAK_W-1:0] streak_q,    streak_d;
  logic [TMO_W-1:0]    tmo_q,       tmo_d;

  logic if_ok;
  logic dm_ok;
  logic data_first;
  logic tmo_hit;
  logic fetch_kill;

  // A requester still seeing its done pulse is finishing the previous access.
  assign if_ok = if_req & ~if_done_q;
  assign dm_ok = dm_req & ~dm_done_q;

  // Data owns the next slot unless fetch has waited through a full streak;
  // while data owns it, fetch may not slip in even if data is momentarily
  // ineligible.
  assign data_first = dm_req & ((streak_q < STREAK_W'(DATA_STREAK_MAX)) | ~if_req);

  assign tmo_hit    = (tmo_q == TMO_W'(TIMEOUT - 1));
  assign fetch_kill = kill_q | branch_flush;

  // Next-state and next-output computation.
  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    mem_req_d   = mem_req_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_done_d   = 1'b0;
    dm_done_d   = 1'b0;
    bus_error_d = 1'b0;
    kill_d      = kill_q;
    streak_d    = streak_q;
    tmo_d       = tmo_q;

    unique case (state_q)
      ARB_IDLE: begin
        if (data_first) begin
          if (dm_ok) begin
            state_d   = ARB_DATA;
            mem_req_d = 1'b1;
            cmd_d.we    = dm_we;
            cmd_d.addr  = dm_addr;
            cmd_d.wdata = dm_wdata;
            cmd_d.be    = dm_be;
            streak_d  = if_req ? streak_q + STREAK_W'(1) : '0;
            tmo_d     = '0;
            kill_d    = 1'b0;
          end
        end else if (if_ok && !branch_flush) begin
          state_d   = ARB_FETCH;
          mem_req_d = 1'b1;
          cmd_d.we    = 1'b0;
          cmd_d.addr  = if_addr;
          cmd_d.wdata = '0;
          cmd_d.be    = FETCH_BE;
          streak_d  = '0;
          tmo_d     = '0;
          kill_d    = 1'b0;
        end
      end

      ARB_FETCH, ARB_DATA: begin
        if (state_q == ARB_FETCH && branch_flush) begin
          kill_d = 1'b1;
        end
        if (mem_ready || tmo_hit) begin
          state_d     = ARB_IDLE;
          mem_req_d   = 1'b0;
          bus_error_d = ~mem_ready;
          if (state_q == ARB_DATA) begin
            dm_done_d = 1'b1;
            if (!mem_ready) begin
              dm_rdata_d = '0;
            end else if (!cmd_q.we) begin
              dm_rdata_d = mem_rdata;
            end
          end else if (!fetch_kill) begin
            if_done_d  = 1'b1;
            if_rdata_d = mem_ready ? mem_rdata : '0;
          end
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end

      default: begin
        state_d   = ARB_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops the memory request at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ARB_IDLE;
      cmd_q       <= '0;
      mem_req_q   <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_done_q   <= 1'b0;
      dm_done_q   <= 1'b0;
      bus_error_q <= 1'b0;
      kill_q      <= 1'b0;
      streak_q    <= '0;
      tmo_q       <= '0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      mem_req_q   <= mem_req_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      if_done_q   <= if_done_d;
      dm_done_q   <= dm_done_d;
      bus_error_q <= bus_error_d;
      kill_q      <= kill_d;
      streak_q    <= streak_d;
      tmo_q       <= tmo_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = cmd_q.we;
  assign mem_addr  = cmd_q.addr;
  assign mem_wdata = cmd_q.wdata;
  assign mem_be    = cmd_q.be;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign if_done   = if_done_q;
  assign dm_done   = dm_done_q;
  assign bus_error = bus_error_q;

  // Stalls release in the same cycle the completion pulse is seen.
  assign if_stall = if_req & ~if_done_q;
  assign dm_stall = dm_req & ~dm_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: table of request scenarios with expected grant
// order, a memory model, a grant/completion scoreboard and hand sequences.
module tb_mem_port_arbiter;

  localparam logic [31:0] IF_BASE = 32'h00400020;
  localparam logic [31:0] DM_BASE = 32'h10010000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_done;
  logic        if_stall;
  logic        branch_flush = 1'b0;
  logic        dm_req = 1'b0;
  logic        dm_we = 1'b0;
  logic [31:0] dm_addr = '0;
  logic [31:0] dm_wdata = '0;
  logic [3:0]  dm_be = '0;
  logic [31:0] dm_rdata;
  logic        dm_done;
  logic        dm_stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;
  logic        bus_error;

  always #5 clk = ~clk;

  mem_port_arbiter #(.DATA_STREAK_MAX(4), .TIMEOUT(255)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .if_stall(if_stall), .branch_flush(branch_flush),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_be(dm_be), .dm_rdata(dm_rdata), .dm_done(dm_done), .dm_stall(dm_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .bus_error(bus_error)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        is_if;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] rdata;
    logic        berr;
  } exp_t;

  typedef struct {
    int          n_if;
    int          n_dm;
    logic        we;
    int          lat;
    int          n_gnt;
    logic [15:0] order;   // bit g = 1: grant g goes to fetch
  } vec_t;

  exp_t gnt_q[$];
  exp_t done_q[$];
  exp_t mon_g, mon_d, e;
  vec_t vecs[6];
  vec_t v;

  logic [31:0] model_if = '0;
  logic [31:0] model_dm = '0;
  logic [31:0] prev_if;
  int          if_left = 0, dm_left = 0, if_idx = 0, dm_idx = 0;
  logic        vec_we = 1'b0;
  logic        auto_drv = 1'b0;
  int          mem_lat = 1;
  int          mem_wait = 0;
  logic        stray_ready = 1'b0;
  logic        req_seen = 1'b0;
  int          cyc = 0, if_t = 0, dm_t = 0;
  int          fi, di, n;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    if (a == 32'h00400020) return 32'h27bdffd0;
    return {a[15:0], 16'h0} ^ {16'h0, a[31:16]} ^ 32'h0000a5c3;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Memory model: answers after mem_lat cycles of mem_req (0 = never).
  always @(negedge clk) begin
    if (mem_req) begin
      mem_wait++;
      mem_ready = (mem_lat != 0) && (mem_wait >= mem_lat);
      mem_rdata = mem_fn(mem_addr);
    end else begin
      mem_wait  = 0;
      mem_ready = stray_ready;
      mem_rdata = 32'hbad0bad0;
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: grants and completions in expected order.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_req && !req_seen) begin
        if (gnt_q.size() == 0) begin
          chk("grant_unexpected", mem_addr, 32'hffffffff);
        end else begin
          mon_g = gnt_q.pop_front();
          chk("gnt_we", 32'(mem_we), 32'(mon_g.we));
          chk("gnt_addr", mem_addr, mon_g.addr);
          chk("gnt_be", 32'(mem_be), 32'(mon_g.be));
          if (mon_g.we) chk("gnt_wdata", mem_wdata, mon_g.wdata);
        end
      end
      if (if_done || dm_done) begin
        if (if_done) if_t = cyc;
        if (dm_done) dm_t = cyc;
        if (done_q.size() == 0) begin
          chk("done_unexpected", {30'b0, if_done, dm_done}, 32'h0);
        end else begin
          mon_d = done_q.pop_front();
          chk("done_side", 32'(if_done), 32'(mon_d.is_if));
          chk("done_rdata", mon_d.is_if ? if_rdata : dm_rdata, mon_d.rdata);
          chk("done_berr", 32'(bus_error), 32'(mon_d.berr));
        end
      end
    end
    req_seen = mem_req;
  end

  task automatic drive_auto();
    if_req   = (if_left > 0);
    if_addr  = IF_BASE + 32'(if_idx) * 32'd4;
    dm_req   = (dm_left > 0);
    dm_we    = vec_we;
    dm_addr  = DM_BASE + 32'(dm_idx) * 32'd4;
    dm_wdata = 32'hc0de0000 + 32'(dm_idx);
    dm_be    = 4'(dm_idx + 1);
  endtask

  // One clock; in auto mode acts as both requesters, re-requesting at once.
  task automatic cycle();
    @(posedge clk);
    #1;
    if (auto_drv) begin
      if (if_req) chk("if_stall", 32'(if_stall), 32'(!if_done));
      if (dm_req) chk("dm_stall", 32'(dm_stall), 32'(!dm_done));
      if (if_done) begin if_left--; if_idx++; end
      if (dm_done) begin dm_left--; dm_idx++; end
      drive_auto();
    end
  endtask

  task automatic drain(input int bound);
    int c;
    c = 0;
    while (done_q.size() > 0 || (auto_drv && (if_left > 0 || dm_left > 0))) begin
      if (c == bound) begin
        chk("drain_timeout", 32'(done_q.size()), 32'd0);
        done_q.delete();
        gnt_q.delete();
        if_left = 0;
        dm_left = 0;
        break;
      end
      cycle();
      c++;
      if (!auto_drv) begin
        if (if_done) if_req = 1'b0;
        if (dm_done) dm_req = 1'b0;
      end
    end
  endtask

  task automatic push_both(input exp_t x);
    gnt_q.push_back(x);
    done_q.push_back(x);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    //            n_if n_dm we    lat gnts order
    vecs[0] = '{1, 0, 1'b0, 1, 1,  16'b1};
    vecs[1] = '{1, 1, 1'b0, 1, 2,  16'b10};
    vecs[2] = '{3, 9, 1'b0, 1, 12, 16'h0A10};
    vecs[3] = '{2, 2, 1'b1, 3, 4,  16'b1100};
    vecs[4] = '{0, 3, 1'b1, 2, 3,  16'b0};
    vecs[5] = '{2, 1, 1'b0, 2, 3,  16'b110};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_mem_be", 32'(mem_be), 0);
    chk("rst_done", {30'b0, if_done, dm_done}, 0);
    chk("rst_berr", 32'(bus_error), 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_dm_rdata", dm_rdata, 0);
    if_req = 1'b1;
    dm_req = 1'b1;
    #1;
    chk("rst_if_stall", 32'(if_stall), 1);
    chk("rst_dm_stall", 32'(dm_stall), 1);
    if_req = 1'b0;
    dm_req = 1'b0;
    rst_n  = 1'b1;

    // Stray mem_ready while idle is ignored
    stray_ready = 1'b1;
    repeat (3) cycle();
    chk("stray_req", 32'(mem_req), 0);
    chk("stray_done", {30'b0, if_done, dm_done}, 0);
    stray_ready = 1'b0;
    cycle();

    // Table-driven scenarios
    for (int i = 0; i < 6; i++) begin
      v  = vecs[i];
      fi = 0;
      di = 0;
      for (int g = 0; g < v.n_gnt; g++) begin
        if (v.order[g]) begin
          e.is_if = 1'b1; e.we = 1'b0; e.addr = IF_BASE + 32'(fi) * 32'd4;
          e.wdata = '0; e.be = 4'hF; e.rdata = mem_fn(e.addr); e.berr = 1'b0;
          model_if = e.rdata;
          fi++;
        end else begin
          e.is_if = 1'b0; e.we = v.we; e.addr = DM_BASE + 32'(di) * 32'd4;
          e.wdata = 32'hc0de0000 + 32'(di); e.be = 4'(di + 1);
          e.rdata = v.we ? model_dm : mem_fn(e.addr); e.berr = 1'b0;
          model_dm = e.rdata;
          di++;
        end
        push_both(e);
      end
      if_left  = v.n_if;
      dm_left  = v.n_dm;
      if_idx   = 0;
      dm_idx   = 0;
      vec_we   = v.we;
      mem_lat  = v.lat;
      auto_drv = 1'b1;
      drive_auto();
      drain(400);
      if (i == 1) chk("done_gap", 32'(if_t - dm_t), 32'd2);
      cycle();
    end
    auto_drv = 1'b0;
    chk("vec_if_rdata", if_rdata, model_if);
    chk("vec_dm_rdata", dm_rdata, model_dm);

    // Branch flush: blocks grant in IDLE, kills an in-flight fetch
    prev_if = model_if;
    mem_lat = 4;
    e.is_if = 1'b1; e.we = 1'b0; e.wdata = '0; e.be = 4'hF; e.berr = 1'b0;
    e.addr = 32'h00400100; e.rdata = 32'h0;
    gnt_q.push_back(e);
    e.addr = 32'h00400200; e.rdata = mem_fn(e.addr);
    push_both(e);
    model_if = e.rdata;
    if_req = 1'b1;
    if_addr = 32'h00400100;
    branch_flush = 1'b1;
    cycle();
    chk("flush_idle_block", 32'(mem_req), 0);
    branch_flush = 1'b0;
    cycle();
    chk("fetch_granted", 32'(mem_req), 1);
    branch_flush = 1'b1;
    if_addr = 32'h00400200;
    cycle();
    branch_flush = 1'b0;
    for (int c = 0; c < 20 && mem_req; c++) begin
      chk("kill_addr_hold", mem_addr, 32'h00400100);
      cycle();
    end
    chk("kill_idle", 32'(mem_req), 0);
    chk("kill_no_done", 32'(if_done), 0);
    chk("kill_rdata", if_rdata, prev_if);
    drain(50);
    cycle();

    // Watchdog timeout on a load that memory never answers
    mem_lat = 0;
    e.is_if = 1'b0; e.we = 1'b0; e.addr = 32'h10010040; e.wdata = '0;
    e.be = 4'h3; e.rdata = 32'h0; e.berr = 1'b1;
    push_both(e);
    model_dm = 32'h0;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h10010040; dm_be = 4'h3;
    cycle();
    n = 0;
    for (int c = 0; c < 300 && mem_req; c++) begin
      n++;
      cycle();
    end
    chk("tmo_cycles", 32'(n), 32'd255);
    chk("tmo_req", 32'(mem_req), 0);
    chk("tmo_dm_done", 32'(dm_done), 1);
    chk("tmo_berr", 32'(bus_error), 1);
    chk("tmo_rdata", dm_rdata, 0);
    dm_req = 1'b0;
    cycle();
    chk("tmo_berr_pulse", 32'(bus_error), 0);
    chk("tmo_idle_req", 32'(mem_req), 0);

    // Reset asserted mid-fetch, then a fresh fetch
    e.is_if = 1'b1; e.we = 1'b0; e.addr = 32'h00400300; e.wdata = '0;
    e.be = 4'hF; e.rdata = 32'h0; e.berr = 1'b0;
    gnt_q.push_back(e);
    if_req = 1'b1;
    if_addr = 32'h00400300;
    repeat (3) cycle();
    chk("pre_rst_req", 32'(mem_req), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_req", 32'(mem_req), 0);
    chk("midrst_if_done", 32'(if_done), 0);
    chk("midrst_berr", 32'(bus_error), 0);
    chk("midrst_stall", 32'(if_stall), 1);
    chk("midrst_dm_rdata", dm_rdata, 0);
    repeat (2) cycle();
    mem_lat = 1;
    e.rdata = mem_fn(e.addr);
    push_both(e);
    rst_n = 1'b1;
    drain(50);
    chk("post_rst_if_rdata", if_rdata, mem_fn(32'h00400300));
    cycle();
    chk("end_gnt_q", 32'(gnt_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
